// File: rtl/liteic_pkg.sv
// Shared liteic definitions: arbiter state encoding and the round-robin request mask.
package liteic_pkg;

  localparam int unsigned LITEIC_MAX_MASTERS = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } liteic_arb_state_e;

  // Bits strictly below the last granted index; callers truncate to their master count.
  function automatic logic [LITEIC_MAX_MASTERS-1:0] liteic_below_mask(input int unsigned idx);
    logic [LITEIC_MAX_MASTERS-1:0] one;
    one = LITEIC_MAX_MASTERS'(1);
    return (one << idx) - one;
  endfunction

endpackage

// File: rtl/liteic_priority_cd.sv
// Priority coder: reports the highest set request bit as a one-hot vector and a binary index.
module liteic_priority_cd #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
  input  logic [IN_WIDTH-1:0]  req,
  output logic [IN_WIDTH-1:0]  onehot,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 valid
);

  // Ascending scan so the last (highest) set bit overwrites any lower one.
  always_comb begin
    onehot = '0;
    out    = '0;
    valid  = 1'b0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        out       = OUT_WIDTH'(i);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/liteic_rr_arbiter.sv
// Round-robin arbiter for one liteic slave port; grant held until done_i or watchdog expiry.
module liteic_rr_arbiter
  import liteic_pkg::*;
#(
  parameter int NUM_MASTERS    = 20,
  parameter int IDX_WIDTH      = $clog2(NUM_MASTERS),
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_WIDTH       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic                   done_i,
  output logic                   grant_valid_o,
  output logic [NUM_MASTERS-1:0] grant_onehot_o,
  output logic [IDX_WIDTH-1:0]   grant_idx_o,
  output logic                   timeout_o
);

  liteic_arb_state_e      state_q;
  logic [IDX_WIDTH-1:0]   last_q;
  logic [TO_WIDTH-1:0]    wd_cnt_q;

  logic [NUM_MASTERS-1:0] masked_req;
  logic [NUM_MASTERS-1:0] masked_onehot;
  logic [NUM_MASTERS-1:0] full_onehot;
  logic [IDX_WIDTH-1:0]   masked_idx;
  logic [IDX_WIDTH-1:0]   full_idx;
  logic                   masked_valid;
  logic                   full_valid;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic                   wd_expire;

  assign masked_req = req_i & NUM_MASTERS'(liteic_below_mask(32'(last_q)));

  liteic_priority_cd #(
    .IN_WIDTH  (NUM_MASTERS),
    .OUT_WIDTH (IDX_WIDTH)
  ) u_masked_cd (
    .req    (masked_req),
    .onehot (masked_onehot),
    .out    (masked_idx),
    .valid  (masked_valid)
  );

  liteic_priority_cd #(
    .IN_WIDTH  (NUM_MASTERS),
    .OUT_WIDTH (IDX_WIDTH)
  ) u_full_cd (
    .req    (req_i),
    .onehot (full_onehot),
    .out    (full_idx),
    .valid  (full_valid)
  );

  // Prefer masters below the last grant; otherwise wrap around to the highest requester.
  assign win_onehot = masked_valid ? masked_onehot : full_onehot;
  assign win_idx    = masked_valid ? masked_idx    : full_idx;

  assign wd_expire = (TIMEOUT_CYCLES > 0) && (wd_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      last_q         <= '0;
      wd_cnt_q       <= '0;
      grant_valid_o  <= 1'b0;
      grant_onehot_o <= '0;
      grant_idx_o    <= '0;
      timeout_o      <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (full_valid) begin
            grant_valid_o  <= 1'b1;
            grant_onehot_o <= win_onehot;
            grant_idx_o    <= win_idx;
            wd_cnt_q       <= '0;
            state_q        <= BUSY;
          end
        end
        BUSY: begin
          // A completion on the expiry cycle wins, so timeout_o only fires without done_i.
          if (done_i || wd_expire) begin
            grant_valid_o  <= 1'b0;
            grant_onehot_o <= '0;
            grant_idx_o    <= '0;
            last_q         <= grant_idx_o;
            timeout_o      <= ~done_i;
            state_q        <= IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  unused_full_onehot_check: assert property (@(posedge clk_i) disable iff (rst_i)
    grant_valid_o |-> (grant_onehot_o == (NUM_MASTERS'(1) << grant_idx_o)));

endmodule

// File: tb/tb_liteic_rr_arbiter.sv
// Directed bench for liteic_rr_arbiter with four masters and an eight-cycle watchdog.
module tb_liteic_rr_arbiter;

  localparam int NM = 4;
  localparam int IW = 2;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic [NM-1:0] req;
  logic          done;
  logic          grant_valid;
  logic [NM-1:0] grant_onehot;
  logic [IW-1:0] grant_idx;
  logic          timeout;

  int tests_run;
  int tests_failed;

  liteic_rr_arbiter #(
    .NUM_MASTERS    (NM),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .done_i         (done),
    .grant_valid_o  (grant_valid),
    .grant_onehot_o (grant_onehot),
    .grant_idx_o    (grant_idx),
    .timeout_o      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [NM-1:0] r, input logic d);
    req  = r;
    done = d;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    applyStimulus('0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst = 1'b1;
    applyStimulus(4'b1010, 1'b0);
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 8'h00);
    end
    rst = 1'b0;
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== {1'b1, 4'b1000, 2'd3, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL first_grant: got %b expected %b", obs, {1'b1, 4'b1000, 2'd3, 1'b0});
    end
    applyStimulus('0, 1'b1);
    tick();
    applyStimulus('0, 1'b0);
    tests_run++;
    if (grant_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL first_release: got %b expected 0", grant_valid);
    end
  endtask

  task automatic test_rotation();
    logic [IW-1:0] exp_idx [5];
    logic [7:0]    obs;
    logic [7:0]    exp;
    exp_idx = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    reset_dut();
    applyStimulus(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = {grant_valid, grant_onehot, grant_idx, timeout};
      exp = {1'b1, 4'b0001 << exp_idx[i], exp_idx[i], 1'b0};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("[TB] FAIL rotation_grant[%0d]: got %b expected %b", i, obs, exp);
      end
      applyStimulus(4'b1111, 1'b1);
      tick();
      applyStimulus((i == 4) ? 4'b0000 : 4'b1111, 1'b0);
      tests_run++;
      if (grant_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rotation_gap[%0d]: got %b expected 0", i, grant_valid);
      end
    end
  endtask

  task automatic test_req_change();
    logic [7:0] obs;
    reset_dut();
    applyStimulus(4'b0010, 1'b0);
    tick();
    applyStimulus(4'b0101, 1'b0);
    tick();
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== {1'b1, 4'b0010, 2'd1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL hold_during_req_change: got %b expected %b", obs, {1'b1, 4'b0010, 2'd1, 1'b0});
    end
    applyStimulus(4'b0101, 1'b1);
    tick();
    applyStimulus(4'b0101, 1'b0);
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL below_last_grant: got %b expected %b", obs, {1'b1, 4'b0001, 2'd0, 1'b0});
    end
    applyStimulus(4'b0101, 1'b1);
    tick();
    applyStimulus(4'b0101, 1'b0);
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== {1'b1, 4'b0100, 2'd2, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL wrap_grant: got %b expected %b", obs, {1'b1, 4'b0100, 2'd2, 1'b0});
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
  endtask

  task automatic test_timeout();
    logic [7:0] obs;
    reset_dut();
    applyStimulus(4'b0100, 1'b0);
    tick();
    // Requester drops early; the grant must still be held for the full window.
    applyStimulus(4'b0000, 1'b0);
    for (int i = 0; i < TO; i++) begin
      obs = {grant_valid, grant_onehot, grant_idx, timeout};
      tests_run++;
      if (obs !== {1'b1, 4'b0100, 2'd2, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL timeout_hold[%0d]: got %b expected %b", i, obs, {1'b1, 4'b0100, 2'd2, 1'b0});
      end
      tick();
    end
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== {1'b0, 4'b0000, 2'd0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL timeout_expire: got %b expected %b", obs, {1'b0, 4'b0000, 2'd0, 1'b1});
    end
    tick();
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_pulse_width: got %b expected 0", timeout);
    end
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    tests_run++;
    if (grant_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL expiry_cycle_hold: got %b expected 1", grant_valid);
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL done_on_expiry: got %b expected %b", obs, 8'h00);
    end
    tick();
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL done_on_expiry_late: got %b expected 0", timeout);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] obs;
    reset_dut();
    applyStimulus(4'b0100, 1'b0);
    tick();
    applyStimulus(4'b0100, 1'b1);
    tick();
    applyStimulus(4'b0011, 1'b0);
    tick();
    tests_run++;
    if (grant_idx !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_grant: got %0d expected 1", grant_idx);
    end
    #2 rst = 1'b1;
    #1;
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_clear: got %b expected %b", obs, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== {1'b1, 4'b0010, 2'd1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_grant: got %b expected %b", obs, {1'b1, 4'b0010, 2'd1, 1'b0});
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
  endtask

  task automatic test_done_idle();
    logic [7:0] obs;
    applyStimulus(4'b0000, 1'b1);
    tick();
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL done_while_idle: got %b expected %b", obs, 8'h00);
    end
    applyStimulus(4'b1111, 1'b0);
    tick();
    obs = {grant_valid, grant_onehot, grant_idx, timeout};
    tests_run++;
    if (obs !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL last_kept_after_idle_done: got %b expected %b", obs, {1'b1, 4'b0001, 2'd0, 1'b0});
    end
    applyStimulus(4'b0000, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    req          = '0;
    done         = 1'b0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_req_change();
    test_timeout();
    test_async_reset();
    test_done_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
